// File: rtl/truth_table_checker.sv
// Drives all 16 A/B/C/D vectors onto a small logic DUT, captures its output per vector,
// and compares the captured truth table against an expected pattern.
`timescale 1ns/1ps

module truth_table_checker #(
    parameter int          DWELL    = 20,
    parameter logic [15:0] EXPECTED = 16'hF888
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail_idx
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // DRIVE | vector idx on a..d, dwell counter running
    // DONE  | run finished, results stable until next start
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] dwell_cnt;
    logic [3:0]    idx;
    logic          launch;
    logic          sample_now;
    logic          miss;
    logic [4:0]    mismatch_nxt;

    assign launch       = start && ((state == IDLE) || (state == DONE));
    assign sample_now   = (state == DRIVE) && (dwell_cnt == DWELL_LAST);
    assign miss         = (f_in != EXPECTED[idx]);
    assign mismatch_nxt = mismatch_count + {4'd0, miss};

    assign {a, b, c, d} = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   if (sample_now && (idx == 4'd15)) state_nxt = DONE;
            DONE:    if (start) state_nxt = DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == DRIVE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt      <= '0;
            idx            <= 4'd0;
            captured       <= 16'd0;
            mismatch_count <= 5'd0;
            first_fail_idx <= 4'd0;
            pass           <= 1'b0;
        end else if (launch) begin
            dwell_cnt      <= '0;
            idx            <= 4'd0;
            captured       <= 16'd0;
            mismatch_count <= 5'd0;
            first_fail_idx <= 4'd0;
            pass           <= 1'b0;
        end else if (state == DRIVE) begin
            if (sample_now) begin
                captured[idx]  <= f_in;
                mismatch_count <= mismatch_nxt;
                // count still zero before this sample means this is the first miss
                if (miss && (mismatch_count == 5'd0)) begin
                    first_fail_idx <= idx;
                end
                if (idx == 4'd15) begin
                    pass <= (mismatch_nxt == 5'd0);
                end else begin
                    idx       <= idx + 4'd1;
                    dwell_cnt <= '0;
                end
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

endmodule
